// File: rtl/mixer_ctrl.sv
// Mixer sequencer: accepts interpolated samples, tags each with the fs/4 LO code
// (+1, 0, -1, 0), and registers the mixer result into a backpressured output stage.
module mixer_ctrl #(
    parameter int T_BITS   = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [1:0]          phase_i,
    input  logic [T_BITS-1:0]   interp_i,
    input  logic                interp_valid_i,
    output logic                interp_ready_o,
    output logic [1:0]          lo_o,
    output logic [T_BITS-1:0]   mix_data_o,
    input  logic [T_BITS-1:0]   mix_i,
    output logic [T_BITS-1:0]   out_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o,
    output logic [CNT_BITS-1:0] sample_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [1:0]  start;
    logic        a_valid;
    logic [1:0]  a_code;
    logic        a_move;
    logic        accept_state;
    logic        accept;

    function automatic logic [1:0] lo_code(input logic [1:0] i);
        case (i)
            2'd0:    return 2'b01;
            2'd2:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // DRAIN keeps accepting until the phase index returns to its start value,
    // so every run covers a whole number of LO periods.
    always_comb begin
        a_move         = a_valid && (!out_valid_o || out_ready_i);
        accept_state   = (state == RUN) || ((state == DRAIN) && (idx != start));
        interp_ready_o = accept_state && (!a_valid || a_move);
        accept         = interp_valid_i && interp_ready_o;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en_i) state_next = RUN;
            RUN:     if (!en_i) state_next = DRAIN;
            DRAIN:   if ((idx == start) && !accept) state_next = FLUSH;
            FLUSH:   if (!a_valid && !out_valid_o) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= 2'd0;
            start        <= 2'd0;
            sample_cnt_o <= '0;
        end else if ((state == IDLE) && en_i) begin
            idx          <= phase_i;
            start        <= phase_i;
            sample_cnt_o <= '0;
        end else if (accept) begin
            idx          <= idx + 2'd1;
            sample_cnt_o <= sample_cnt_o + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid    <= 1'b0;
            a_code     <= 2'b00;
            mix_data_o <= '0;
        end else if (accept) begin
            a_valid    <= 1'b1;
            a_code     <= lo_code(idx);
            mix_data_o <= interp_i;
        end else if (a_move) begin
            a_valid    <= 1'b0;
        end
    end

    // out_o only changes on a move, which keeps it stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_o       <= '0;
            out_valid_o <= 1'b0;
        end else if (a_move) begin
            out_o       <= mix_i;
            out_valid_o <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    assign lo_o   = a_valid ? a_code : 2'b00;
    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_mixer_ctrl.sv
// Testbench for mixer_ctrl: directed scenarios plus randomized runs, checked against
// a transaction-level model of LO sequencing and output ordering.
module tb_mixer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [1:0]  phase_i;
    logic [15:0] interp_i;
    logic        interp_valid_i;
    logic        interp_ready_o;
    logic [1:0]  lo_o;
    logic [15:0] mix_data_o;
    logic [15:0] mix_i;
    logic [15:0] out_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        busy_o;
    logic [15:0] sample_cnt_o;

    int checks = 0;
    int errors = 0;

    mixer_ctrl #(.T_BITS(16), .CNT_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .phase_i(phase_i),
        .interp_i(interp_i), .interp_valid_i(interp_valid_i), .interp_ready_o(interp_ready_o),
        .lo_o(lo_o), .mix_data_o(mix_data_o), .mix_i(mix_i),
        .out_o(out_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .sample_cnt_o(sample_cnt_o)
    );

    always #5 clk = ~clk;

    // Stand-in mixer: scale by 0x2860/2^15, +1 passes, -1 is the ones' complement.
    function automatic logic [15:0] mixer(input logic [15:0] x, input logic [1:0] lo);
        logic signed [31:0] p;
        p = $signed({{16{x[15]}}, x}) * 32'sd10336;
        p = p >>> 15;
        case (lo)
            2'b01:   return p[15:0];
            2'b10:   return ~p[15:0];
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [1:0] ref_code(input logic [1:0] i);
        case (i)
            2'd0:    return 2'b01;
            2'd1:    return 2'b00;
            2'd2:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    always_comb mix_i = mixer(mix_data_o, lo_o);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 300) begin
            tick();
            n++;
        end
        check_output(tag, 32'(busy_o), 32'd0);
    endtask

    // Reference model: per-run LO sequence from the latched phase and an ordered
    // queue of expected mixed outputs.
    logic [15:0] exp_q[$];
    logic        prev_acc;
    logic        prev_stall;
    logic        prev_busy;
    logic [1:0]  prev_lo;
    logic [15:0] prev_sample;
    logic [15:0] prev_out;
    logic [1:0]  model_idx;
    int          run_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_acc   = 1'b0;
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
            model_idx  = 2'd0;
            run_acc    = 0;
        end else begin
            if (prev_acc) begin
                check_output("mon_lo", 32'(lo_o), 32'(prev_lo));
                check_output("mon_mix_data", 32'(mix_data_o), 32'(prev_sample));
            end
            if (prev_stall) begin
                check_output("mon_out_stable", 32'(out_o), 32'(prev_out));
                check_output("mon_out_held", 32'(out_valid_o), 32'd1);
            end
            if (busy_o && !prev_busy) begin
                model_idx = phase_i;
                run_acc   = 0;
            end
            if (!busy_o && prev_busy) begin
                check_output("mon_period", 32'(run_acc % 4), 32'd0);
                check_output("mon_drained", 32'(exp_q.size()), 32'd0);
            end
            check_output("mon_cnt", 32'(sample_cnt_o), 32'(run_acc % 65536));
            check_output("mon_ready_idle", 32'(interp_ready_o & ~busy_o), 32'd0);
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) check_output("mon_out_extra", 32'd1, 32'd0);
                else                   check_output("mon_out", 32'(out_o), 32'(exp_q.pop_front()));
            end
            prev_acc = interp_valid_i && interp_ready_o;
            if (prev_acc) begin
                prev_lo     = ref_code(model_idx);
                prev_sample = interp_i;
                exp_q.push_back(mixer(interp_i, prev_lo));
                model_idx   = model_idx + 2'd1;
                run_acc++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_out   = out_o;
            prev_busy  = busy_o;
        end
    end

    initial begin
        logic [1:0]  got_lo [8];
        logic [15:0] got_out[8];
        logic [1:0]  exp_lo [8];
        logic [15:0] exp_out[8];
        logic [15:0] hs_q[$];
        int          n;
        int          len;

        exp_lo  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        exp_out = '{16'h1430, 16'h0000, 16'hEBCF, 16'h0000,
                    16'h1430, 16'h0000, 16'hEBCF, 16'h0000};

        rst_n = 1'b0; en_i = 1'b0; phase_i = 2'd0; interp_i = 16'h0000;
        interp_valid_i = 1'b0; out_ready_i = 1'b1;
        #12;
        check_output("rst_ready", 32'(interp_ready_o), 32'd0);
        check_output("rst_lo", 32'(lo_o), 32'd0);
        check_output("rst_mix_data", 32'(mix_data_o), 32'd0);
        check_output("rst_out", 32'(out_o), 32'd0);
        check_output("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_output("rst_busy", 32'(busy_o), 32'd0);
        check_output("rst_cnt", 32'(sample_cnt_o), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] steady run");
        interp_i = 16'h4000; interp_valid_i = 1'b1; en_i = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            if (k == 8) en_i = 1'b0;
            tick();
            if (k <= 8) got_lo[k-1] = lo_o;
            if (k >= 2) got_out[k-2] = out_o;
        end
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("steady_lo%0d", i), 32'(got_lo[i]), 32'(exp_lo[i]));
            check_output($sformatf("steady_out%0d", i), 32'(got_out[i]), 32'(exp_out[i]));
        end
        check_output("steady_cnt", 32'(sample_cnt_o), 32'd8);
        wait_idle("steady_idle");
        tick();

        $display("[TB] phase offset and stop mid-period");
        phase_i = 2'd2; en_i = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 4) got_lo[k-1] = lo_o;
        end
        en_i = 1'b0;
        for (int i = 0; i < 4; i++)
            check_output($sformatf("phase_lo%0d", i), 32'(got_lo[i]), 32'(exp_lo[(i + 2) % 4]));
        wait_idle("stop_idle");
        check_output("stop_cnt", 32'(sample_cnt_o), 32'd8);
        check_output("stop_last_idx", 32'(model_idx - 2'd1), 32'd1);
        tick();
        check_output("stop_ready_low", 32'(interp_ready_o), 32'd0);

        $display("[TB] backpressure");
        phase_i = 2'd0; interp_i = 16'h4000; out_ready_i = 1'b0; en_i = 1'b1;
        tick();
        tick();
        check_output("bp_ready_after_1", 32'(interp_ready_o), 32'd1);
        tick();
        check_output("bp_ready_drop", 32'(interp_ready_o), 32'd0);
        en_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_output("bp_out_stall", 32'(out_o), 32'h1430);
        end
        out_ready_i = 1'b1;
        n = 0;
        while (busy_o && n < 50) begin
            if (out_valid_o && out_ready_i) hs_q.push_back(out_o);
            tick();
            n++;
        end
        check_output("bp_idle", 32'(busy_o), 32'd0);
        check_output("bp_count", 32'(hs_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_q.size(); i++)
            check_output($sformatf("bp_out%0d", i), 32'(hs_q[i]), 32'(exp_out[i]));

        $display("[TB] re-enable during flush");
        tick();
        en_i = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) tick();
        en_i = 1'b0;
        tick();
        out_ready_i = 1'b0;
        tick();
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        tick();
        check_output("flush_busy", 32'(busy_o), 32'd1);
        check_output("flush_ready", 32'(interp_ready_o), 32'd0);
        check_output("flush_cnt", 32'(sample_cnt_o), 32'd4);
        en_i = 1'b1;
        out_ready_i = 1'b1;
        wait_idle("flush_to_idle");
        tick();
        check_output("reen_busy", 32'(busy_o), 32'd1);
        check_output("reen_cnt", 32'(sample_cnt_o), 32'd0);
        check_output("reen_ready", 32'(interp_ready_o), 32'd1);
        en_i = 1'b0;
        wait_idle("reen_idle");
        tick();

        $display("[TB] async reset mid-run");
        phase_i = 2'd1; out_ready_i = 1'b0; en_i = 1'b1;
        tick();
        tick();
        tick();
        check_output("pre_rst_full", 32'(out_valid_o), 32'd1);
        check_output("pre_rst_lo", 32'(lo_o), 32'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_ready", 32'(interp_ready_o), 32'd0);
        check_output("arst_lo", 32'(lo_o), 32'd0);
        check_output("arst_mix_data", 32'(mix_data_o), 32'd0);
        check_output("arst_out", 32'(out_o), 32'd0);
        check_output("arst_out_valid", 32'(out_valid_o), 32'd0);
        check_output("arst_busy", 32'(busy_o), 32'd0);
        check_output("arst_cnt", 32'(sample_cnt_o), 32'd0);
        en_i = 1'b0; out_ready_i = 1'b1;
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("post_rst_no_out", 32'(out_valid_o), 32'd0);
        end

        $display("[TB] randomized runs");
        for (int r = 0; r < 8; r++) begin
            phase_i = 2'($urandom_range(0, 3));
            en_i    = 1'b1;
            len     = $urandom_range(3, 30);
            for (int i = 0; i < len; i++) begin
                interp_valid_i = 1'($urandom_range(0, 1));
                out_ready_i    = ($urandom_range(0, 3) != 0);
                interp_i       = 16'($urandom);
                tick();
            end
            en_i = 1'b0;
            n = 0;
            while (busy_o && n < 300) begin
                interp_valid_i = 1'($urandom_range(0, 1));
                out_ready_i    = ($urandom_range(0, 3) != 0);
                interp_i       = 16'($urandom);
                tick();
                n++;
            end
            check_output("rand_idle", 32'(busy_o), 32'd0);
            tick();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
